// File: rtl/adi_spi_7_8bit_engine.sv
// SPI mode-0 shift engine: one 16-bit {rw, addr[6:0], data[7:0]} frame per command, MSB first.
// Optional 3-wire SDIO turnaround via `ADI_SPI_3WIRE_EN (adds spi_sdio_oe).
module adi_spi_7_8bit_engine #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic       S_AXI_ACLK,
    input  logic       S_AXI_ARESETN,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       spi_csn,
    output logic       spi_sclk,
    output logic       spi_mosi,
`ifdef ADI_SPI_3WIRE_EN
    output logic       spi_sdio_oe,
`endif
    input  logic       spi_miso
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int GAP_N = (CS_IDLE < 1) ? 1 : CS_IDLE;
    localparam int T_A   = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int T_MAX = (T_A > GAP_N) ? T_A : GAP_N;
    localparam int TMR_W = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [TMR_W-1:0] tmr_q;
    logic [3:0]       bit_q;
    logic [14:0]      sh_q;
    logic [7:0]       rx_q;
    logic             rw_q;
    logic             ready_q;
    logic             rsp_valid_q;
    logic [7:0]       rdata_q;
    logic             busy_q;
    logic             csn_q;
    logic             sclk_q;
    logic             mosi_q;
`ifdef ADI_SPI_3WIRE_EN
    logic             oe_q;
`endif

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            tmr_q       <= '0;
            bit_q       <= '0;
            rw_q        <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            csn_q       <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
`ifdef ADI_SPI_3WIRE_EN
            oe_q        <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (cmd_valid && ready_q) begin
                        // Read frames carry zeros in the data phase; bit15 goes out directly.
                        sh_q    <= {cmd_addr, (cmd_rw ? 8'h00 : cmd_wdata)};
                        rw_q    <= cmd_rw;
                        mosi_q  <= cmd_rw;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        csn_q   <= 1'b0;
                        tmr_q   <= TMR_W'(CS_SETUP - 1);
`ifdef ADI_SPI_3WIRE_EN
                        oe_q    <= 1'b1;
`endif
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (tmr_q == '0) begin
                        div_q   <= DIV_W'(CLK_DIV - 1);
                        bit_q   <= 4'd15;
                        state_q <= S_SHIFT;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (div_q != '0) begin
                        div_q <= div_q - 1'b1;
                    end else begin
                        div_q <= DIV_W'(CLK_DIV - 1);
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            rx_q   <= {rx_q[6:0], spi_miso};
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_q == 4'd0) begin
                                mosi_q  <= 1'b0;
                                tmr_q   <= TMR_W'(CS_HOLD - 1);
`ifdef ADI_SPI_3WIRE_EN
                                oe_q    <= 1'b0;
`endif
                                state_q <= S_HOLD;
                            end else begin
                                bit_q  <= bit_q - 4'd1;
                                mosi_q <= sh_q[14];
                                sh_q   <= {sh_q[13:0], 1'b0};
`ifdef ADI_SPI_3WIRE_EN
                                // Release SDIO once the last address bit has been clocked out.
                                if (rw_q && bit_q == 4'd8) begin
                                    oe_q <= 1'b0;
                                end
`endif
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (tmr_q == '0) begin
                        csn_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rdata_q     <= rw_q ? rx_q : 8'h00;
                        tmr_q       <= TMR_W'(GAP_N - 1);
                        state_q     <= S_GAP;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                S_GAP: begin
                    if (tmr_q == '0) begin
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign busy      = busy_q;
    assign spi_csn   = csn_q;
    assign spi_sclk  = sclk_q;
    assign spi_mosi  = mosi_q;
`ifdef ADI_SPI_3WIRE_EN
    assign spi_sdio_oe = oe_q;
`endif

endmodule

// File: tb/tb_adi_spi_7_8bit_engine.sv
// Randomized self-checking bench for adi_spi_7_8bit_engine with a behavioural SPI slave model.
// Define ADI_SPI_3WIRE_EN to also check the SDIO turnaround.
module tb_adi_spi_7_8bit_engine;

    localparam int D  = 2;
    localparam int CS = 2;
    localparam int CH = 2;
    localparam int CI = 4;
    localparam int LAT    = 1 + CS + 32 * D + CH;
    localparam int CS_LOW = CS + 32 * D + CH;

    logic       clk = 1'b0;
    logic       rstn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       spi_csn;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
`ifdef ADI_SPI_3WIRE_EN
    logic       spi_sdio_oe;
`endif

    int checks = 0;
    int failures = 0;

    adi_spi_7_8bit_engine #(
        .CLK_DIV (D),
        .CS_SETUP(CS),
        .CS_HOLD (CH),
        .CS_IDLE (CI)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rstn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_rw       (cmd_rw),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .busy         (busy),
        .spi_csn      (spi_csn),
        .spi_sclk     (spi_sclk),
        .spi_mosi     (spi_mosi),
`ifdef ADI_SPI_3WIRE_EN
        .spi_sdio_oe  (spi_sdio_oe),
`endif
        .spi_miso     (spi_miso)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Slave model: shifts slave_byte out during the last 8 bits, updating after each SCLK fall.
    logic [7:0]  slave_byte = 8'h00;
    int          fall_cnt = 0;
    logic [15:0] mosi_word = 16'h0;
    int          rises = 0;
    int          sclk_idle_err = 0;
    int          oe_err = 0;
    logic        cur_rw = 1'b0;
    int          rsp_cnt = 0;
    int          ready_err = 0;
    int          hi_run = 0;
    int          last_gap = 0;

    always @(negedge spi_sclk) fall_cnt++;

    always_comb begin
        spi_miso = 1'b0;
        if (fall_cnt >= 8 && fall_cnt < 16) spi_miso = slave_byte[3'(15 - fall_cnt)];
    end

    always @(posedge spi_sclk) begin
        if (spi_csn !== 1'b0) sclk_idle_err++;
`ifdef ADI_SPI_3WIRE_EN
        if (spi_sdio_oe !== ((cur_rw && rises >= 8) ? 1'b0 : 1'b1)) oe_err++;
`endif
        mosi_word = {mosi_word[14:0], spi_mosi};
        rises++;
    end

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) rsp_cnt++;
        if (busy === 1'b1 && cmd_ready === 1'b1) ready_err++;
`ifdef ADI_SPI_3WIRE_EN
        if (spi_csn === 1'b1 && spi_sdio_oe !== 1'b0) oe_err++;
`endif
        if (spi_csn === 1'b1) hi_run++;
        else begin
            if (hi_run > 0) last_gap = hi_run;
            hi_run = 0;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_val("ready_wait", 32'(n < 2000), 32'd1);
    endtask

    task automatic do_cmd(input logic rw, input logic [6:0] addr, input logic [7:0] wd,
                          input logic [7:0] sb, input bit keep_valid, input bit poke);
        int lat;
        int lowc;
        logic [15:0] exp_word;
        logic [7:0]  exp_rd;
        exp_word = {rw, addr, (rw ? 8'h00 : wd)};
        exp_rd   = rw ? sb : 8'h00;
        wait_ready();
        slave_byte = sb;
        cur_rw     = rw;
        rises      = 0;
        fall_cnt   = 0;
        mosi_word  = 16'h0;
        oe_err     = 0;
        cmd_valid  = 1'b1;
        cmd_rw     = rw;
        cmd_addr   = addr;
        cmd_wdata  = wd;
        @(negedge clk);
        lat  = 1;
        lowc = (spi_csn === 1'b0) ? 1 : 0;
        check_val("busy_after_accept", 32'(busy), 32'd1);
        check_val("ready_after_accept", 32'(cmd_ready), 32'd0);
        if (!keep_valid) cmd_valid = 1'b0;
        while (rsp_valid !== 1'b1 && lat < 1000) begin
            if (poke && lat == 20) begin
                cmd_valid = 1'b1;
                cmd_rw    = ~rw;
                cmd_addr  = ~addr;
                cmd_wdata = ~wd;
            end else if (poke && lat == 22) begin
                check_val("ready_while_poked", 32'(cmd_ready), 32'd0);
                cmd_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (spi_csn === 1'b0) lowc++;
        end
        check_val("latency", 32'(lat), 32'(LAT));
        check_val("csn_low_cycles", 32'(lowc), 32'(CS_LOW));
        check_val("sclk_rises", 32'(rises), 32'd16);
        check_val("mosi_word", 32'(mosi_word), 32'(exp_word));
        check_val("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        check_val("csn_at_rsp", 32'(spi_csn), 32'd1);
        check_val("sclk_at_rsp", 32'(spi_sclk), 32'd0);
`ifdef ADI_SPI_3WIRE_EN
        check_val("oe_at_rsp", 32'(spi_sdio_oe), 32'd0);
        check_val("oe_errors", 32'(oe_err), 32'd0);
`endif
        @(negedge clk);
        check_val("rsp_pulse_width", 32'(rsp_valid), 32'd0);
        check_val("rsp_rdata_held", 32'(rsp_rdata), 32'(exp_rd));
    endtask

    initial begin
        int n;
        int rsp0;
        rstn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_rw    = 1'b0;
        cmd_addr  = 7'h0;
        cmd_wdata = 8'h0;
        repeat (3) @(negedge clk);
        check_val("rst_ready", 32'(cmd_ready), 32'd0);
        check_val("rst_csn", 32'(spi_csn), 32'd1);
        check_val("rst_sclk", 32'(spi_sclk), 32'd0);
        check_val("rst_mosi", 32'(spi_mosi), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_rdata", 32'(rsp_rdata), 32'd0);
`ifdef ADI_SPI_3WIRE_EN
        check_val("rst_oe", 32'(spi_sdio_oe), 32'd0);
`endif
        rstn = 1'b1;
        @(negedge clk);
        check_val("ready_after_release", 32'(cmd_ready), 32'd1);

        do_cmd(1'b0, 7'h15, 8'hA5, 8'h00, 1'b0, 1'b0);
        do_cmd(1'b1, 7'h7F, 8'h00, 8'h3C, 1'b0, 1'b0);

        // Two back-to-back writes with cmd_valid held high throughout.
        do_cmd(1'b0, 7'h2A, 8'h5A, 8'h00, 1'b1, 1'b0);
        do_cmd(1'b0, 7'h2A, 8'h5A, 8'h00, 1'b0, 1'b0);
        check_val("gap_cycles_min", 32'(last_gap >= CI), 32'd1);

        do_cmd(1'b1, 7'h33, 8'hFF, 8'hC3, 1'b0, 1'b1);
        do_cmd(1'b1, 7'h02, 8'h00, 8'h96, 1'b0, 1'b0);

        // Abort a frame after its 7th SCLK rise.
        wait_ready();
        rises      = 0;
        fall_cnt   = 0;
        cmd_valid  = 1'b1;
        cmd_rw     = 1'b1;
        cmd_addr   = 7'h11;
        cmd_wdata  = 8'h00;
        slave_byte = 8'hFF;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (rises < 7 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_val("abort_reach_rise7", 32'(rises), 32'd7);
        rsp0 = rsp_cnt;
        rstn = 1'b0;
        @(negedge clk);
        check_val("abort_csn", 32'(spi_csn), 32'd1);
        check_val("abort_sclk", 32'(spi_sclk), 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_ready", 32'(cmd_ready), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_val("abort_ready_release", 32'(cmd_ready), 32'd1);
        repeat (100) @(negedge clk);
        check_val("abort_no_rsp", 32'(rsp_cnt - rsp0), 32'd0);
        do_cmd(1'b0, 7'h15, 8'hA5, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            do_cmd(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom),
                   1'b0, 1'($urandom_range(0, 1)));
        end

        check_val("sclk_while_csn_high", 32'(sclk_idle_err), 32'd0);
        check_val("busy_and_ready", 32'(ready_err), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
